// File: rtl/seven_segment_driver.sv
// Multiplexed 4-digit hex display driver with active-low segment and digit outputs.
// Define SEVEN_SEGMENT_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seven_segment_driver #(
  parameter int unsigned REFRESH_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_in,
  output logic [6:0]  segments_n,
  output logic [3:0]  digit_en_n,
  output logic        frame_strobe
);

  logic [15:0] prescaler;
  logic [1:0]  index;
  logic [15:0] shadow;

  logic        tick;
  logic        boundary;
  logic [1:0]  next_index;
  logic [15:0] next_shadow;
  logic [3:0]  nibble;
  logic        blank;
  logic [6:0]  next_segments;

  function automatic logic [6:0] encode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick        = (prescaler == 16'(REFRESH_DIV - 1));
  assign next_index  = index + 2'd1;
  assign boundary    = tick && (next_index == 2'd0);
  // On a frame boundary the freshly sampled value drives the first digit directly.
  assign next_shadow = boundary ? value_in : shadow;

  always_comb begin
    nibble = 4'h0;
    blank  = 1'b0;
    case (next_index)
      2'd0: nibble = next_shadow[3:0];
      2'd1: begin
        nibble = next_shadow[7:4];
`ifdef SEVEN_SEGMENT_BLANK_EN
        blank = (next_shadow[15:4] == 12'h000);
`endif
      end
      2'd2: begin
        nibble = next_shadow[11:8];
`ifdef SEVEN_SEGMENT_BLANK_EN
        blank = (next_shadow[15:8] == 8'h00);
`endif
      end
      default: begin
        nibble = next_shadow[15:12];
`ifdef SEVEN_SEGMENT_BLANK_EN
        blank = (next_shadow[15:12] == 4'h0);
`endif
      end
    endcase
    next_segments = blank ? 7'h7F : encode(nibble);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler    <= 16'h0000;
      index        <= 2'd3;
      shadow       <= 16'h0000;
      segments_n   <= 7'h7F;
      digit_en_n   <= 4'hF;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= boundary;
      if (tick) begin
        prescaler  <= 16'h0000;
        index      <= next_index;
        shadow     <= next_shadow;
        segments_n <= next_segments;
        digit_en_n <= ~(4'b0001 << next_index);
      end else begin
        prescaler <= prescaler + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_driver.sv
// Bench for seven_segment_driver at REFRESH_DIV=4: frame vectors feed an expected queue,
// every cycle is checked for hold/update, plus reset and mid-frame reset sequences.
module tb_seven_segment_driver;

  localparam int DIV = 4;
`ifdef SEVEN_SEGMENT_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] value_in;
  logic [6:0]  segments_n;
  logic [3:0]  digit_en_n;
  logic        frame_strobe;

  int errors = 0;
  int checks = 0;

  // {strobe, digit_en_n, segments_n}
  logic [11:0] exp_q[$];
  logic [6:0]  held_seg;
  logic [3:0]  held_dig;

  typedef struct {
    logic [15:0]      value;
    logic [3:0][6:0]  segs;       // [3]=digit 3 ... [0]=digit 0
    int               change_at;  // digit index after which value_in changes, -1 = never
    logic [15:0]      new_value;
  } vec_t;

  seven_segment_driver #(.REFRESH_DIV(DIV)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .value_in(value_in),
    .segments_n(segments_n),
    .digit_en_n(digit_en_n),
    .frame_strobe(frame_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [3:0][6:0] segs);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] dig;
      dig = ~(4'b0001 << i);
      exp_q.push_back({(i == 0), dig, segs[i]});
    end
  endtask

  // Wait one digit slot: outputs must hold for DIV-1 cycles, then update on the tick edge.
  task automatic run_tick(input string tag);
    logic [11:0] e;
    for (int c = 1; c < DIV; c++) begin
      @(posedge clk); #1;
      check({tag, " hold seg"}, {25'd0, segments_n}, {25'd0, held_seg});
      check({tag, " hold dig"}, {28'd0, digit_en_n}, {28'd0, held_dig});
      check({tag, " hold strobe"}, {31'd0, frame_strobe}, 32'd0);
    end
    @(posedge clk); #1;
    if (exp_q.size() == 0) begin
      check({tag, " queue empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, " tick seg"}, {25'd0, segments_n}, {25'd0, e[6:0]});
      check({tag, " tick dig"}, {28'd0, digit_en_n}, {28'd0, e[10:7]});
      check({tag, " tick strobe"}, {31'd0, frame_strobe}, {31'd0, e[11]});
      held_seg = e[6:0];
      held_dig = e[10:7];
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " seg"}, {25'd0, segments_n}, 32'h7F);
    check({tag, " dig"}, {28'd0, digit_en_n}, 32'hF);
    check({tag, " strobe"}, {31'd0, frame_strobe}, 32'd0);
    held_seg = 7'h7F;
    held_dig = 4'hF;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{16'hA80F, {7'h08, 7'h00, 7'h40, 7'h0E}, -1, 16'h0000};
    vecs[1] = '{16'h1111, {7'h79, 7'h79, 7'h79, 7'h79},  1, 16'h2222};
    vecs[2] = '{16'h2222, {7'h24, 7'h24, 7'h24, 7'h24}, -1, 16'h0000};
    vecs[3] = '{16'h0005, {LZ,    LZ,    LZ,    7'h12}, -1, 16'h0000};
    vecs[4] = '{16'h0000, {LZ,    LZ,    LZ,    7'h40}, -1, 16'h0000};
    vecs[5] = '{16'h0F00, {LZ,    7'h0E, 7'h40, 7'h40}, -1, 16'h0000};

    // Reset held low with a non-zero value present.
    rst_n    = 1'b0;
    value_in = 16'h1234;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // First frame after release: digit 0 appears DIV cycles later with a strobe.
    push_frame({7'h79, 7'h24, 7'h30, 7'h19});
    for (int i = 0; i < 4; i++) run_tick("reset_frame");

    // Vector frames; value_in is applied right after the previous frame's last digit.
    for (int v = 0; v < 6; v++) begin
      value_in = vecs[v].value;
      push_frame(vecs[v].segs);
      for (int i = 0; i < 4; i++) begin
        run_tick($sformatf("vec%0d", v));
        if (i == vecs[v].change_at) value_in = vecs[v].new_value;
      end
    end

    // Reset pulse while digit 2 is displayed abandons the frame.
    value_in = 16'h1234;
    push_frame({7'h79, 7'h24, 7'h30, 7'h19});
    for (int i = 0; i < 3; i++) run_tick("pre_midreset");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push_frame({7'h79, 7'h24, 7'h30, 7'h19});
    for (int i = 0; i < 4; i++) run_tick("post_midreset");

    check("queue drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
